// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, deframes
// 11-bit frames, tracks E0/F0 prefixes and keeps held-key levels for the
// game controls. Define PS2_WASD_EN to add W/A/S/D as alternates to the arrows.
`timescale 1ns/1ps
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       raw_left,
    output logic       raw_right,
    output logic       raw_down,
    output logic       raw_rotate,
    output logic       raw_drop,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic       frame_err
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall_edge;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          ext_flag, brk_flag;
    logic          frame_ok;
    logic [3:0]    arrow_held;
    logic          drop_held;
    logic          hit_left, hit_right, hit_down, hit_rotate, hit_drop;
`ifdef PS2_WASD_EN
    logic [3:0]    wasd_held;
    logic          hit_a, hit_d, hit_s, hit_w;
`endif

    // Two-flop synchronizers; reset to the idle-high bus level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: accept a new ps2_clk level after FILTER_LEN equal samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            clk_filt <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign fall_edge = (clk_s2 != clk_filt) && (filt_cnt == FILT_LAST) && clk_filt;

    // Odd parity over data plus parity bit, and the stop bit (current sample) high
    assign frame_ok = (^{shreg, par_bit}) & dat_s2;

    assign hit_left   = ext_flag  && (shreg == 8'h6B);
    assign hit_right  = ext_flag  && (shreg == 8'h74);
    assign hit_down   = ext_flag  && (shreg == 8'h72);
    assign hit_rotate = ext_flag  && (shreg == 8'h75);
    assign hit_drop   = !ext_flag && (shreg == 8'h29);
`ifdef PS2_WASD_EN
    assign hit_a = !ext_flag && (shreg == 8'h1C);
    assign hit_d = !ext_flag && (shreg == 8'h23);
    assign hit_s = !ext_flag && (shreg == 8'h1B);
    assign hit_w = !ext_flag && (shreg == 8'h1D);
`endif

    // Frame FSM with timeout, prefix tracking and held-key level updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            key_valid  <= 1'b0;
            frame_err  <= 1'b0;
            key_code   <= 8'h00;
            key_ext    <= 1'b0;
            key_brk    <= 1'b0;
            arrow_held <= '0;
            drop_held  <= 1'b0;
`ifdef PS2_WASD_EN
            wasd_held  <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (fall_edge && !dat_s2) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                default: begin
                    if (fall_edge) begin
                        tmo_cnt <= '0;
                        case (state)
                            DATA: begin
                                shreg   <= {dat_s2, shreg[7:1]};
                                bit_cnt <= bit_cnt + 1'b1;
                                if (bit_cnt == 3'd7) state <= PARITY;
                            end
                            PARITY: begin
                                par_bit <= dat_s2;
                                state   <= STOP;
                            end
                            default: begin
                                state <= IDLE;
                                if (!frame_ok) begin
                                    frame_err <= 1'b1;
                                    ext_flag  <= 1'b0;
                                    brk_flag  <= 1'b0;
                                end else if (shreg == 8'hE0) begin
                                    ext_flag <= 1'b1;
                                end else if (shreg == 8'hF0) begin
                                    brk_flag <= 1'b1;
                                end else begin
                                    key_valid <= 1'b1;
                                    key_code  <= shreg;
                                    key_ext   <= ext_flag;
                                    key_brk   <= brk_flag;
                                    ext_flag  <= 1'b0;
                                    brk_flag  <= 1'b0;
                                    if (hit_left)   arrow_held[0] <= !brk_flag;
                                    if (hit_right)  arrow_held[1] <= !brk_flag;
                                    if (hit_down)   arrow_held[2] <= !brk_flag;
                                    if (hit_rotate) arrow_held[3] <= !brk_flag;
                                    if (hit_drop)   drop_held     <= !brk_flag;
`ifdef PS2_WASD_EN
                                    if (hit_a) wasd_held[0] <= !brk_flag;
                                    if (hit_d) wasd_held[1] <= !brk_flag;
                                    if (hit_s) wasd_held[2] <= !brk_flag;
                                    if (hit_w) wasd_held[3] <= !brk_flag;
`endif
                                end
                            end
                        endcase
                    end else if (tmo_cnt == TMO_LAST) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        ext_flag  <= 1'b0;
                        brk_flag  <= 1'b0;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef PS2_WASD_EN
    assign raw_left   = arrow_held[0] | wasd_held[0];
    assign raw_right  = arrow_held[1] | wasd_held[1];
    assign raw_down   = arrow_held[2] | wasd_held[2];
    assign raw_rotate = arrow_held[3] | wasd_held[3];
`else
    assign raw_left   = arrow_held[0];
    assign raw_right  = arrow_held[1];
    assign raw_down   = arrow_held[2];
    assign raw_rotate = arrow_held[3];
`endif
    assign raw_drop = drop_held;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random
// key events checked against a scancode-level reference model.
`timescale 1ns/1ps
module tb_ps2_key_decoder;
    localparam int FILTER_LEN  = 2;
    localparam int TIMEOUT_CYC = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       raw_left, raw_right, raw_down, raw_rotate, raw_drop;
    logic       key_valid, key_ext, key_brk, frame_err;
    logic [7:0] key_code;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_fall = 0;
    int fe_cnt = 0;
    int fe_cyc = 0;
    int both_cnt = 0;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [4:0] raw;
    } kv_t;

    kv_t kv_q[$];
    kv_t exp_q[$];

    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [4:0] m_arrow = '0;
    logic [4:0] m_wasd = '0;

    ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .raw_left(raw_left), .raw_right(raw_right), .raw_down(raw_down),
        .raw_rotate(raw_rotate), .raw_drop(raw_drop),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_brk(key_brk), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] raw_vec();
        return {raw_drop, raw_rotate, raw_down, raw_right, raw_left};
    endfunction

    always @(negedge clk) begin
        if (key_valid) kv_q.push_back('{key_code, key_ext, key_brk, raw_vec()});
        if (frame_err) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
        if (key_valid && frame_err) both_cnt = both_cnt + 1;
    end

    function automatic int arrow_idx(input logic ext, input logic [7:0] c);
        if (ext && c == 8'h6B) return 0;
        if (ext && c == 8'h74) return 1;
        if (ext && c == 8'h72) return 2;
        if (ext && c == 8'h75) return 3;
        if (!ext && c == 8'h29) return 4;
        return -1;
    endfunction

    function automatic int wasd_idx(input logic ext, input logic [7:0] c);
`ifdef PS2_WASD_EN
        if (!ext && c == 8'h1C) return 0;
        if (!ext && c == 8'h23) return 1;
        if (!ext && c == 8'h1B) return 2;
        if (!ext && c == 8'h1D) return 3;
`else
        if (ext && c == 8'h00) return -1;
`endif
        return -1;
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic bad_stop, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
        ps2_data = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int ai;
        int wi;
        send_frame(b, 1'b0, 1'b0, 11);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            ai = arrow_idx(m_ext, b);
            wi = wasd_idx(m_ext, b);
            if (ai >= 0) m_arrow[ai] = !m_brk;
            if (wi >= 0) m_wasd[wi] = !m_brk;
            exp_q.push_back('{b, m_ext, m_brk, m_arrow | m_wasd});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        n_checks++;
        if (raw_vec() !== 5'b0) begin n_fail++; $display("FAIL reset_raw: got %b expected 00000", raw_vec()); end
        n_checks++;
        if ({key_valid, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {key_valid, frame_err}); end
        n_checks++;
        if (key_code !== 8'h00) begin n_fail++; $display("FAIL reset_code: got %h expected 00", key_code); end
        n_checks++;
        if ({key_ext, key_brk} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {key_ext, key_brk}); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_arrow_make_break();
        int fe0;
        kv_q.delete(); exp_q.delete(); fe0 = fe_cnt;
        send_byte(8'hE0);
        send_byte(8'h6B);
        n_checks++;
        if (kv_q.size() != 1) begin n_fail++; $display("FAIL left_make_count: got %0d expected 1", kv_q.size()); end
        else begin
            n_checks++;
            if ({kv_q[0].code, kv_q[0].ext, kv_q[0].brk} !== {8'h6B, 2'b10}) begin
                n_fail++; $display("FAIL left_make_fields: got %h/%b/%b expected 6b/1/0", kv_q[0].code, kv_q[0].ext, kv_q[0].brk);
            end
            n_checks++;
            if (kv_q[0].raw !== 5'b00001) begin n_fail++; $display("FAIL left_make_same_cycle: got %b expected 00001", kv_q[0].raw); end
        end
        n_checks++;
        if (raw_left !== 1'b1) begin n_fail++; $display("FAIL left_held: got %b expected 1", raw_left); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        n_checks++;
        if (kv_q.size() != 1) begin n_fail++; $display("FAIL prefix_no_valid: got %0d expected 1", kv_q.size()); end
        send_byte(8'h6B);
        n_checks++;
        if (kv_q.size() != 2) begin n_fail++; $display("FAIL left_break_count: got %0d expected 2", kv_q.size()); end
        else begin
            n_checks++;
            if ({kv_q[1].code, kv_q[1].ext, kv_q[1].brk} !== {8'h6B, 2'b11}) begin
                n_fail++; $display("FAIL left_break_fields: got %h/%b/%b expected 6b/1/1", kv_q[1].code, kv_q[1].ext, kv_q[1].brk);
            end
        end
        n_checks++;
        if (raw_left !== 1'b0) begin n_fail++; $display("FAIL left_released: got %b expected 0", raw_left); end
        n_checks++;
        if (fe_cnt != fe0) begin n_fail++; $display("FAIL arrow_no_err: got %0d expected %0d", fe_cnt, fe0); end
    endtask

    task automatic test_frame_errors();
        int fe0;
        kv_q.delete(); exp_q.delete(); fe0 = fe_cnt;
        send_byte(8'hE0);
        send_frame(8'h29, 1'b1, 1'b0, 11);
        m_ext = 1'b0; m_brk = 1'b0;
        n_checks++;
        if (fe_cnt != fe0 + 1) begin n_fail++; $display("FAIL parity_err_pulse: got %0d expected %0d", fe_cnt, fe0 + 1); end
        n_checks++;
        if (kv_q.size() != 0) begin n_fail++; $display("FAIL parity_no_valid: got %0d expected 0", kv_q.size()); end
        n_checks++;
        if (raw_drop !== 1'b0) begin n_fail++; $display("FAIL parity_drop: got %b expected 0", raw_drop); end
        send_byte(8'h6B);
        n_checks++;
        if (kv_q.size() != 1) begin n_fail++; $display("FAIL after_err_count: got %0d expected 1", kv_q.size()); end
        else begin
            n_checks++;
            if ({kv_q[0].ext, kv_q[0].raw[0]} !== 2'b00) begin
                n_fail++; $display("FAIL after_err_ext_cleared: got %b expected 00", {kv_q[0].ext, kv_q[0].raw[0]});
            end
        end
        send_frame(8'h29, 1'b0, 1'b1, 11);
        n_checks++;
        if (fe_cnt != fe0 + 2) begin n_fail++; $display("FAIL stop_err_pulse: got %0d expected %0d", fe_cnt, fe0 + 2); end
        n_checks++;
        if (kv_q.size() != 1 || raw_drop !== 1'b0) begin n_fail++; $display("FAIL stop_err_discard: got %0d/%b expected 1/0", kv_q.size(), raw_drop); end
    endtask

    task automatic test_timeout();
        int fe0;
        int waited;
        int delta;
        kv_q.delete(); exp_q.delete(); fe0 = fe_cnt; waited = 0;
        send_frame(8'h29, 1'b0, 1'b0, 5);
        while (fe_cnt == fe0 && waited < 1500) begin
            @(negedge clk);
            waited++;
        end
        m_ext = 1'b0; m_brk = 1'b0;
        delta = fe_cyc - last_fall;
        n_checks++;
        if (fe_cnt != fe0 + 1) begin n_fail++; $display("FAIL timeout_pulse: got %0d errors expected 1", fe_cnt - fe0); end
        else begin
            n_checks++;
            if (delta < TIMEOUT_CYC || delta > TIMEOUT_CYC + 10) begin
                n_fail++; $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d", delta, TIMEOUT_CYC, TIMEOUT_CYC + 10);
            end
        end
        send_byte(8'h29);
        n_checks++;
        if (kv_q.size() != 1 || raw_drop !== 1'b1) begin n_fail++; $display("FAIL timeout_recover: got %0d/%b expected 1/1", kv_q.size(), raw_drop); end
    endtask

    task automatic test_wasd();
        logic exp_left;
`ifdef PS2_WASD_EN
        exp_left = 1'b1;
`else
        exp_left = 1'b0;
`endif
        kv_q.delete(); exp_q.delete();
        send_byte(8'h1C);
        n_checks++;
        if (kv_q.size() != 1) begin n_fail++; $display("FAIL wasd_count: got %0d expected 1", kv_q.size()); end
        else begin
            n_checks++;
            if (kv_q[0].code !== 8'h1C) begin n_fail++; $display("FAIL wasd_code: got %h expected 1c", kv_q[0].code); end
        end
        n_checks++;
        if (raw_left !== exp_left) begin n_fail++; $display("FAIL wasd_left: got %b expected %b", raw_left, exp_left); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        n_checks++;
        if (raw_left !== 1'b0) begin n_fail++; $display("FAIL wasd_release: got %b expected 0", raw_left); end
    endtask

    task automatic test_random();
        for (int e = 0; e < 20; e++) begin
            int kind;
            logic [7:0] code;
            logic ext;
            logic brk;
            kv_t got;
            kv_t exp;
            kv_q.delete(); exp_q.delete();
            kind = int'($urandom_range(0, 9));
            ext = 1'b0;
            case (kind)
                0: begin code = 8'h6B; ext = 1'b1; end
                1: begin code = 8'h74; ext = 1'b1; end
                2: begin code = 8'h72; ext = 1'b1; end
                3: begin code = 8'h75; ext = 1'b1; end
                4: code = 8'h29;
                5: code = 8'h1C;
                6: code = 8'h23;
                7: code = 8'h1B;
                8: code = 8'h1D;
                default: begin
                    code = 8'($urandom_range(0, 255));
                    if (code == 8'hE0 || code == 8'hF0 || code == 8'h1C || code == 8'h23 || code == 8'h1B || code == 8'h1D) code = 8'h12;
                    ext = 1'($urandom_range(0, 1));
                end
            endcase
            brk = 1'($urandom_range(0, 1));
            if (ext) send_byte(8'hE0);
            if (brk) send_byte(8'hF0);
            send_byte(code);
            n_checks++;
            if (kv_q.size() != 1 || exp_q.size() != 1) begin
                n_fail++; $display("FAIL rand_count[%0d]: got %0d expected 1", e, kv_q.size());
            end else begin
                got = kv_q[0];
                exp = exp_q[0];
                n_checks++;
                if ({got.code, got.ext, got.brk} !== {exp.code, exp.ext, exp.brk}) begin
                    n_fail++; $display("FAIL rand_fields[%0d]: got %h/%b/%b expected %h/%b/%b", e, got.code, got.ext, got.brk, exp.code, exp.ext, exp.brk);
                end
                n_checks++;
                if (got.raw !== exp.raw) begin n_fail++; $display("FAIL rand_raw[%0d]: got %b expected %b", e, got.raw, exp.raw); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int fe0;
        kv_q.delete(); exp_q.delete();
        send_byte(8'hE0);
        send_byte(8'h6B);
        send_byte(8'hE0);
        send_byte(8'h74);
        n_checks++;
        if ({raw_right, raw_left} !== 2'b11) begin n_fail++; $display("FAIL both_held: got %b expected 11", {raw_right, raw_left}); end
        fe0 = fe_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (raw_vec() !== 5'b0) begin n_fail++; $display("FAIL async_reset_raw: got %b expected 00000", raw_vec()); end
        ps2_data = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0; m_arrow = '0; m_wasd = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        n_checks++;
        if (fe_cnt != fe0) begin n_fail++; $display("FAIL reset_no_err: got %0d expected %0d", fe_cnt, fe0); end
        kv_q.delete(); exp_q.delete();
        send_byte(8'h29);
        n_checks++;
        if (kv_q.size() != 1 || raw_drop !== 1'b1) begin n_fail++; $display("FAIL resync: got %0d/%b expected 1/1", kv_q.size(), raw_drop); end
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (both_cnt != 0) begin n_fail++; $display("FAIL valid_err_overlap: got %0d expected 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_arrow_make_break();
        test_frame_errors();
        test_timeout();
        test_wasd();
        test_random();
        test_reset_mid_frame();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: cycles ps2_clk must hold a new synchronized level before the level is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 200000: max clk cycles between falling edges inside a frame (2 ms at 100 MHz).
REQ-003 SHALL have ports: clk  input  1  system clock, rising-edge.
REQ-004 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports: ps2_clk  input  1  PS/2 clock, asynchronous to clk.
REQ-006 SHALL have ports: ps2_data  input  1  PS/2 data, asynchronous to clk.
REQ-007 SHALL have ports: raw_left, raw_right, raw_down, raw_rotate, raw_drop  output  1 each  held-key levels that feed the input manager.
REQ-008 SHALL have ports: key_valid  output  1  one-cycle pulse per decoded non-prefix scancode.
REQ-009 SHALL have ports: key_code  output  8  last decoded byte; key_ext  output  1  E0 prefix seen; key_brk  output  1  F0 prefix seen.
REQ-010 SHALL have ports: frame_err  output  1  one-cycle pulse on parity, start, stop or timeout error.

Function
REQ-011 SHALL synchronize ps2_clk and ps2_data through 2 flip-flops each before any use.
REQ-012 SHALL filter the synchronized ps2_clk: the accepted level changes only after FILTER_LEN consecutive equal samples; a falling edge is an accepted 1->0 change.
REQ-013 SHALL sample synchronized ps2_data on each accepted falling edge.
REQ-014 SHALL use FSM IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE.
REQ-015 IDLE: sampled 0 -> DATA with bit counter cleared; sampled 1 -> stay in IDLE, no error.
REQ-016 SHALL check odd parity over the 8 data bits plus the parity bit, and require stop bit = 1.
REQ-017 SHALL treat a byte as valid only when parity and stop are both good; otherwise pulse frame_err, discard the byte, clear the ext and brk flags, and return to IDLE.
REQ-018 SHALL count cycles since the last falling edge while in DATA, PARITY or STOP; reaching TIMEOUT_CYC -> IDLE, frame_err pulse, flags cleared.
REQ-019 Valid byte E0 -> set ext flag; valid byte F0 -> set brk flag; neither produces key_valid.
REQ-020 Other valid byte -> key_valid pulses 1 cycle after the stop-bit falling edge is accepted; key_code, key_ext and key_brk take the byte and the flags; flags then clear.
REQ-021 SHALL map scancode set 2 as: E0 6B -> raw_left, E0 74 -> raw_right, E0 72 -> raw_down, E0 75 -> raw_rotate, 29 (no E0) -> raw_drop.
REQ-022 Mapped make -> level set to 1; mapped break (F0 prefix) -> level set to 0; an unmapped code changes no level; a repeated make leaves the level at 1.
REQ-023 Levels SHALL be independent: simultaneous left and right both read 1; arbitration belongs downstream.
REQ-024 Levels SHALL update in the same cycle that key_valid is asserted.
REQ-025 SHALL never assert key_valid and frame_err in the same cycle.

Reset
REQ-026 rst_n low SHALL asynchronously force: FSM IDLE, counters 0, flags 0, all raw_* 0, key_valid 0, frame_err 0, key_code 8'h00, key_ext 0, key_brk 0, synchronizers and filter to 1 (bus idle).
REQ-027 Reset mid-frame SHALL drop the partial byte without a frame_err; after release, the module resynchronizes on the next start bit.

Configuration
REQ-028 Macro PS2_WASD_EN defined SHALL add alternate mappings, OR-ed with the arrow keys: 1C (A) -> left, 23 (D) -> right, 1B (S) -> down, 1D (W) -> rotate; each alternate key keeps its own held bit.
REQ-029 PS2_WASD_EN undefined SHALL treat 1C, 23, 1B and 1D as unmapped; key_valid and key_code still report them.

Verification (FILTER_LEN=2, TIMEOUT_CYC=1000, PS/2 bit period 40 clk)
REQ-030 Send E0, 6B -> raw_left = 1; key_valid pulses once with key_code 6B, key_ext 1, key_brk 0.
REQ-031 Then send E0, F0, 6B -> raw_left = 0; key_brk = 1; no key_valid on either prefix byte.
REQ-032 Send 29 with the parity bit flipped -> frame_err pulses 1 cycle; raw_drop stays 0; no key_valid.
REQ-033 Stop ps2_clk after 4 data bits -> frame_err 1000 cycles after the last edge; the next clean frame containing 29 sets raw_drop = 1.
REQ-034 Hold E0 6B and E0 74 makes, then assert rst_n = 0 mid-frame -> all raw_* = 0 immediately; no frame_err.
REQ-035 Send 1C -> raw_left = 1 when PS2_WASD_EN is defined, raw_left = 0 when it is not; key_code = 1C in both builds.
